// File: rtl/gate_tt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : gate_tt_sequencer
//  Purpose  : Sweeps an external N_IN-input combinational gate through its
//             full truth table in ascending order. Each vector is held for
//             SETTLE_CYC+1 cycles. The gate output is sampled on the last
//             cycle and compared with a truth table latched at start. The
//             block reports pass/fail, the mismatch count and the first
//             failing vector.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start             - begin a sweep (ignored while busy)
//             exp_table         - expected truth table, bit v = gate_out for v
//             gate_out          - output of the gate under test
//             gate_in           - vector driven onto the gate inputs
//             busy, done, pass  - sweep status (done/pass held until restart)
//             err_count         - number of mismatching vectors
//             first_err_vec     - first mismatching vector
//             first_err_valid   - first_err_vec holds a captured mismatch
//  Revision : 1.0 - initial release
// ============================================================================
module gate_tt_sequencer #(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  exp_table,
    input  logic                  gate_out,
    output logic [N_IN-1:0]       gate_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_IN:0]         err_count,
    output logic [N_IN-1:0]       first_err_vec,
    output logic                  first_err_valid
);

    localparam int c_NVEC  = 1 << N_IN;
    localparam int c_CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]    c_V_LAST   = '1;
    localparam logic [N_IN:0]      c_ERR_ONE  = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state,  w_state_nxt;
    logic [N_IN-1:0]     r_v,      w_v_nxt;
    logic [c_CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [c_NVEC-1:0]   r_exp,    w_exp_nxt;
    logic                r_busy,   w_busy_nxt;
    logic                r_done,   w_done_nxt;
    logic                r_pass,   w_pass_nxt;
    logic [N_IN:0]       r_err,    w_err_nxt;
    logic [N_IN-1:0]     r_fvec,   w_fvec_nxt;
    logic                r_fvalid, w_fvalid_nxt;
    logic                w_mismatch;

    // The vector index doubles as the gate drive; it is parked at 0 in DONE.
    assign gate_in         = r_v;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_err_vec   = r_fvec;
    assign first_err_valid = r_fvalid;

    assign w_mismatch = (gate_out != r_exp[r_v]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_v      <= '0;
            r_cnt    <= '0;
            r_exp    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fvec   <= '0;
            r_fvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_v      <= w_v_nxt;
            r_cnt    <= w_cnt_nxt;
            r_exp    <= w_exp_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_pass   <= w_pass_nxt;
            r_err    <= w_err_nxt;
            r_fvec   <= w_fvec_nxt;
            r_fvalid <= w_fvalid_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_v_nxt      = r_v;
        w_cnt_nxt    = r_cnt;
        w_exp_nxt    = r_exp;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_pass_nxt   = r_pass;
        w_err_nxt    = r_err;
        w_fvec_nxt   = r_fvec;
        w_fvalid_nxt = r_fvalid;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt  = S_SETTLE;
                    w_exp_nxt    = exp_table;
                    w_v_nxt      = '0;
                    w_cnt_nxt    = '0;
                    w_err_nxt    = '0;
                    w_fvec_nxt   = '0;
                    w_fvalid_nxt = 1'b0;
                    w_done_nxt   = 1'b0;
                    w_pass_nxt   = 1'b0;
                    w_busy_nxt   = 1'b1;
                end
            end

            S_SETTLE: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            S_SAMPLE: begin
                if (w_mismatch) begin
                    w_err_nxt = r_err + c_ERR_ONE;
                    if (!r_fvalid) begin
                        w_fvec_nxt   = r_v;
                        w_fvalid_nxt = 1'b1;
                    end
                end
                if (r_v == c_V_LAST) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_v_nxt     = '0;
                    // Pass must account for the sample being taken on this edge.
                    w_pass_nxt  = (r_err == '0) && !w_mismatch;
                end else begin
                    w_state_nxt = S_SETTLE;
                    w_v_nxt     = r_v + N_IN'(1);
                    w_cnt_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_tt_sequencer
//  Purpose  : Self-checking bench for gate_tt_sequencer. A gate model drives
//             gate_out from gate_in. A time-based reference model predicts
//             all outputs every cycle. Directed sweeps pin known results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_tt_sequencer;

    localparam int N_IN       = 2;
    localparam int SETTLE_CYC = 2;
    localparam int NVEC       = 1 << N_IN;
    localparam int PER        = SETTLE_CYC + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [NVEC-1:0]   exp_table = '0;
    logic [NVEC-1:0]   gate_fn = 4'b1000;
    logic              gate_out;
    logic [N_IN-1:0]   gate_in;
    logic              busy, done, pass, first_err_valid;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_err_vec;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    gate_tt_sequencer #(.N_IN(N_IN), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .exp_table       (exp_table),
        .gate_out        (gate_out),
        .gate_in         (gate_in),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid)
    );

    // Gate under test: an arbitrary truth table looked up by the driven vector.
    assign gate_out = gate_fn[gate_in];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the elapsed cycles since the accepted start; vector v is sampled
    // (v+1)*PER cycles after start.
    bit          m_busy, m_done, m_pass, m_fvalid;
    int          m_k, m_err, m_fv, m_gin;
    logic [NVEC-1:0] m_exp;

    initial begin
        m_busy = 0; m_done = 0; m_pass = 0; m_fvalid = 0;
        m_k = 0; m_err = 0; m_fv = 0; m_gin = 0; m_exp = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 0; m_done = 0; m_pass = 0; m_fvalid = 0;
                m_k = 0; m_err = 0; m_fv = 0; m_gin = 0;
            end else if (start && !m_busy) begin
                m_exp = exp_table; m_k = 0; m_busy = 1;
                m_done = 0; m_pass = 0; m_err = 0; m_fvalid = 0; m_fv = 0; m_gin = 0;
            end else if (m_busy) begin
                m_k++;
                if (m_k % PER == 0) begin
                    int v;
                    v = m_k / PER - 1;
                    if (gate_out != m_exp[v]) begin
                        m_err++;
                        if (!m_fvalid) begin m_fvalid = 1; m_fv = v; end
                    end
                    if (v == NVEC - 1) begin
                        m_busy = 0; m_done = 1; m_pass = (m_err == 0); m_gin = 0;
                    end else begin
                        m_gin = v + 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("gate_in",         32'(gate_in),         32'(m_gin));
                check("busy",            32'(busy),            32'(m_busy));
                check("done",            32'(done),            32'(m_done));
                check("pass",            32'(pass),            32'(m_pass));
                check("err_count",       32'(err_count),       32'(m_err));
                check("first_err_valid", 32'(first_err_valid), 32'(m_fvalid));
                check("first_err_vec",   32'(first_err_vec),   32'(m_fv));
            end
        end
    end

    // Called at a negedge; returns start-edge-to-done latency in cycles.
    task automatic run_sweep(input int pulse_at, input int exp_change_at, output int lat);
        lat = -1;
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = (c == pulse_at);
            if (c == exp_change_at) exp_table = 4'b0000;
            if (done) begin
                lat = c - 1;
                break;
            end
        end
        start = 1'b0;
        check("sweep_finished", 32'(lat >= 0), 32'd1);
    endtask

    int lat;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err_count), 32'd0);

        // AND gate against its own table
        gate_fn = 4'b1000; exp_table = 4'b1000;
        run_sweep(0, 0, lat);
        check("and_latency", 32'(lat), 32'd12);
        check("and_pass", 32'(pass), 32'd1);
        check("and_err", 32'(err_count), 32'd0);
        check("and_fvalid", 32'(first_err_valid), 32'd0);

        // Output stuck at 0: only vector 3 disagrees
        gate_fn = 4'b0000;
        run_sweep(0, 0, lat);
        check("stuck_err", 32'(err_count), 32'd1);
        check("stuck_fvec", 32'(first_err_vec), 32'd3);
        check("stuck_fvalid", 32'(first_err_valid), 32'd1);
        check("stuck_pass", 32'(pass), 32'd0);

        // OR gate against the AND table: vectors 1 and 2 disagree
        gate_fn = 4'b1110;
        run_sweep(0, 0, lat);
        check("or_err", 32'(err_count), 32'd2);
        check("or_fvec", 32'(first_err_vec), 32'd1);
        check("or_pass", 32'(pass), 32'd0);

        // Start mid-sweep is ignored, then restart from DONE
        gate_fn = 4'b1000;
        run_sweep(5, 0, lat);
        check("busy_start_latency", 32'(lat), 32'd12);
        check("busy_start_pass", 32'(pass), 32'd1);
        gate_fn = 4'b0000;
        run_sweep(0, 0, lat);
        check("restart_latency", 32'(lat), 32'd12);
        check("restart_err", 32'(err_count), 32'd1);

        // Reset while sampling vector 2
        gate_fn = 4'b1000; exp_table = 4'b1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_gate_in", 32'(gate_in), 32'd2);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_gate_in", 32'(gate_in), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        run_sweep(0, 0, lat);
        check("post_rst_latency", 32'(lat), 32'd12);
        check("post_rst_pass", 32'(pass), 32'd1);

        // exp_table change mid-sweep must not matter
        exp_table = 4'b1000;
        run_sweep(0, 4, lat);
        check("exp_change_pass", 32'(pass), 32'd1);
        check("exp_change_err", 32'(err_count), 32'd0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 5) == 0);
            exp_table = 4'($urandom);
            if ($urandom_range(0, 39) == 0) gate_fn = 4'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
